shift_cmd_sequencer: RTL and testbench

Command-driven sequencer that sits directly upstream of the 4-bit bidirectional shifter. It drives the shifter's left/right/clear/inbit inputs and consumes its outbit.
- Accepts queued shift commands over a valid/ready handshake.
- Performs a multi-position shift by iterating single-position shifter steps and feeding outbit back as the next inbit.
- Returns the final word on a result handshake.

---
 rtl/shift_seq_pkg.sv | 28 ++
 rtl/shift_cmd_fifo.sv | 53 +++++
 rtl/shift_cmd_sequencer.sv | 169 ++++++++++++++++
 tb/tb_shift_cmd_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types for the shift command sequencer: op codes,
// FSM state encoding and the packed command word held in the queue.
package shift_seq_pkg;

    localparam int SEQ_WIDTH = 4;
    localparam int SEQ_AMT_W = 3;

    typedef enum logic [1:0] {
        OP_LEFT     = 2'b00,
        OP_RIGHT    = 2'b01,
        OP_CLEAR    = 2'b10,
        OP_PASS_ROT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_CLEAR = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    typedef struct packed {
        op_e                  op;
        logic [SEQ_AMT_W-1:0] amt;
        logic [SEQ_WIDTH-1:0] data;
    } cmd_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous command queue, DEPTH x cmd_t, first-word fall-through
// read port. Ports: clk, rst_n, push/din, pop/dout, full, empty.
module shift_cmd_fifo
    import shift_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Queues shift commands and iterates a 1-position shifter to run them.
// Ports: cmd_* in, sh_* to/from shifter, res_* out, busy. SHIFT_CMD_ROTATE_EN.
module shift_cmd_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH      = SEQ_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int AMT_W      = SEQ_AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0] cmd_amt,
    output logic             sh_left,
    output logic             sh_right,
    output logic             sh_clear,
    output logic [WIDTH-1:0] sh_inbit,
    input  logic [WIDTH-1:0] sh_outbit,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    input  logic             res_ready,
    output logic             busy
);

    state_e           state;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] next_work;

    cmd_t in_cmd;
    cmd_t head;
    logic full;
    logic empty;
    logic push;
    logic pop;

    logic has_amt;
    logic go_shift;
    logic go_clear;
    logic go_rot;

    always_comb begin
        in_cmd      = '0;
        in_cmd.op   = op_e'(cmd_op);
        in_cmd.amt  = cmd_amt;
        in_cmd.data = cmd_data;
    end

    // No bypass: a full queue refuses even when popping this cycle.
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == ST_IDLE) && !empty;

    shift_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (in_cmd),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign sh_inbit = work;
    assign busy     = (state != ST_IDLE) || !empty;

    assign has_amt  = (head.amt != '0);
    assign go_shift = has_amt &&
                      ((head.op == OP_LEFT) || (head.op == OP_RIGHT));
    assign go_clear = (head.op == OP_CLEAR);

`ifdef SHIFT_CMD_ROTATE_EN
    logic rot;

    assign go_rot = has_amt && (head.op == OP_PASS_ROT);

    // Rotate = left shift with the bit shifted out wrapped into bit 0.
    assign next_work = rot ?
        {sh_outbit[WIDTH-1:1], sh_outbit[0] | work[WIDTH-1]} :
        sh_outbit;
`else
    assign go_rot    = 1'b0;
    assign next_work = sh_outbit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            work      <= '0;
            cnt       <= '0;
            sh_left   <= 1'b0;
            sh_right  <= 1'b0;
            sh_clear  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
`ifdef SHIFT_CMD_ROTATE_EN
            rot       <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        work <= head.data;
                        cnt  <= head.amt;
                        unique case (1'b1)
                            go_shift: begin
                                state    <= ST_SHIFT;
                                sh_left  <= (head.op == OP_LEFT);
                                sh_right <= (head.op == OP_RIGHT);
                            end
                            go_clear: begin
                                state    <= ST_CLEAR;
                                sh_clear <= 1'b1;
                            end
                            go_rot: begin
                                state   <= ST_SHIFT;
                                sh_left <= 1'b1;
`ifdef SHIFT_CMD_ROTATE_EN
                                rot     <= 1'b1;
`endif
                            end
                            default: begin
                                // Pass op or zero amount.
                                state     <= ST_DONE;
                                res_valid <= 1'b1;
                                res_data  <= head.data;
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    work <= next_work;
                    cnt  <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state     <= ST_DONE;
                        sh_left   <= 1'b0;
                        sh_right  <= 1'b0;
                        res_valid <= 1'b1;
                        res_data  <= next_work;
`ifdef SHIFT_CMD_ROTATE_EN
                        rot       <= 1'b0;
`endif
                    end
                end
                ST_CLEAR: begin
                    work      <= sh_outbit;
                    sh_clear  <= 1'b0;
                    state     <= ST_DONE;
                    res_valid <= 1'b1;
                    res_data  <= sh_outbit;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Self-checking bench for shift_cmd_sequencer with a 4-bit shifter model.
// Directed scenarios followed by randomized single commands.
module tb_shift_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'h0;
    logic [2:0] cmd_amt = 3'd0;
    logic       sh_left;
    logic       sh_right;
    logic       sh_clear;
    logic [3:0] sh_inbit;
    logic [3:0] sh_outbit;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_ready = 1'b0;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] sb[$];

    int n_left = 0;
    int n_right = 0;
    int n_clear = 0;
    int n_bad = 0;
    logic [3:0] last_in_l = 4'h0;

    int b_left;
    int b_right;
    int b_clear;
    int lat;

    always #5 clk = ~clk;

    shift_cmd_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_amt   (cmd_amt),
        .sh_left   (sh_left),
        .sh_right  (sh_right),
        .sh_clear  (sh_clear),
        .sh_inbit  (sh_inbit),
        .sh_outbit (sh_outbit),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy)
    );

    // Shifter model.
    always_comb begin
        sh_outbit = sh_inbit;
        if (sh_left)
            sh_outbit = {sh_inbit[2:0], 1'b0};
        else if (sh_right)
            sh_outbit = {1'b0, sh_inbit[3:1]};
        else if (sh_clear)
            sh_outbit = 4'h0;
    end

    // Pulse counting and control-exclusivity monitor.
    always @(negedge clk) begin
        if (sh_left) begin
            n_left++;
            last_in_l = sh_inbit;
        end
        if (sh_right)
            n_right++;
        if (sh_clear)
            n_clear++;
        if (int'(sh_left) + int'(sh_right) + int'(sh_clear) > 1)
            n_bad++;
        if (res_valid && (sh_left || sh_right || sh_clear))
            n_bad++;
    end

    function automatic logic [3:0] model(
        input logic [1:0] op,
        input logic [3:0] d,
        input logic [2:0] a
    );
        int x;
        int r;
        x = int'(d);
        r = int'(a) % 4;
        case (op)
            2'b00: return 4'((x << a) & 15);
            2'b01: return 4'(x >> a);
            2'b10: return 4'h0;
            default: begin
`ifdef SHIFT_CMD_ROTATE_EN
                return 4'(((x << r) | (x >> (4 - r))) & 15);
`else
                return d;
`endif
            end
        endcase
    endfunction

    function automatic bit rot_en();
`ifdef SHIFT_CMD_ROTATE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int lat_model(
        input logic [1:0] op,
        input logic [2:0] a
    );
        if (op == 2'b10)
            return 3;
        if (op == 2'b11 && !rot_en())
            return 2;
        return int'(a) + 2;
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_left  = n_left;
        b_right = n_right;
        b_clear = n_clear;
    endtask

    task automatic chk_pulses(
        input string      tag,
        input logic [1:0] op,
        input logic [2:0] a
    );
        int el;
        int er;
        int ec;
        el = (op == 2'b00 || (op == 2'b11 && rot_en())) ?
             int'(a) : 0;
        er = (op == 2'b01) ? int'(a) : 0;
        ec = (op == 2'b10) ? 1 : 0;
        chk({tag, "_left_n"}, n_left - b_left, el);
        chk({tag, "_right_n"}, n_right - b_right, er);
        chk({tag, "_clear_n"}, n_clear - b_clear, ec);
    endtask

    // Called just after a negedge; returns at the negedge after accept.
    task automatic send(
        input logic [1:0] op,
        input logic [3:0] d,
        input logic [2:0] a
    );
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_amt   = a;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                sb.push_back(model(op, d, a));
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_accept", 32'(ok), 1);
    endtask

    // Latency counts negedges since the accept edge.
    task automatic get(output int l);
        bit got;
        logic [3:0] exp;
        got = 1'b0;
        l = 0;
        res_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            l++;
            if (res_valid) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 4'hx;
                chk("res_data", res_data, exp);
                @(posedge clk);
                @(negedge clk);
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
        chk("res_seen", 32'(got), 1);
        chk("res_drop", res_valid, 0);
    endtask

    initial begin
        // Reset state.
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_ctrl", {sh_left, sh_right, sh_clear}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inbit", sh_inbit, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", cmd_ready, 1);
        chk("rel_busy", busy, 0);

        // Left, amt 1.
        snap();
        send(2'b00, 4'b0101, 3'd1);
        get(lat);
        chk("left_lat", lat, 3);
        chk_pulses("left", 2'b00, 3'd1);
        chk("left_inbit", last_in_l, 4'b0101);

        // Right, amt 2.
        snap();
        send(2'b01, 4'b1010, 3'd2);
        get(lat);
        chk("right_lat", lat, 4);
        chk_pulses("right", 2'b01, 3'd2);

        // Clear ignores amt.
        snap();
        send(2'b10, 4'b1111, 3'd5);
        get(lat);
        chk("clear_lat", lat, 3);
        chk_pulses("clear", 2'b10, 3'd5);

        // Pass or rotate.
        snap();
        send(2'b11, 4'b1001, 3'd1);
        get(lat);
        chk("op11_lat", lat, lat_model(2'b11, 3'd1));
        chk_pulses("op11", 2'b11, 3'd1);

        // Backpressure: FSM holds one result, queue holds DEPTH more.
        for (int i = 0; i < 5; i++)
            send(2'(i % 4), 4'($urandom), 3'($urandom_range(0, 7)));
        chk("bp_full", cmd_ready, 0);
        repeat (3) @(negedge clk);
        chk("bp_hold", cmd_ready, 0);
        chk("bp_busy", busy, 1);
        get(lat);
        send(2'b00, 4'b0011, 3'd1);
        for (int i = 0; i < 5; i++)
            get(lat);
        chk("bp_drained", busy, 0);
        chk("bp_sb_empty", sb.size(), 0);

        // Reset in the middle of a shift, with one command queued.
        snap();
        send(2'b00, 4'b0001, 3'd3);
        send(2'b01, 4'b1000, 3'd1);
        chk("mid_shift", sh_left, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_ctrl", {sh_left, sh_right, sh_clear}, 0);
        chk("mid_res_valid", res_valid, 0);
        chk("mid_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        snap();
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_ready", cmd_ready, 1);
        repeat (5) @(negedge clk);
        chk("post_res_valid", res_valid, 0);
        chk_pulses("post", 2'b11, 3'd0);

        // Randomized single commands.
        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            logic [3:0] d;
            logic [2:0] a;
            op = 2'($urandom_range(0, 3));
            d  = 4'($urandom);
            a  = 3'($urandom_range(0, 7));
            snap();
            send(op, d, a);
            get(lat);
            chk("rnd_lat", lat, lat_model(op, a));
            chk_pulses("rnd", op, a);
        end

        chk("ctrl_exclusive", n_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
